branch_target_buffer: RTL and testbench
=======================================

# branch_target_buffer

Direct-mapped branch target buffer with 2-bit saturating direction counters for the pipelined MIPS core. Predicts the next PC in fetch and resolves each prediction when the instruction reaches memory. Produces `btb_correct` and `btb_wrongtype`, which the control unit consumes to steer PC recovery. Sits between the fetch PC mux and the memory-stage pipeline latch.

## Interface
- `ENTRIES`, 16: table depth; power of two, at least 4. `IDXW = $clog2(ENTRIES)`.
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `pc_f` in 32 (`word_t`): fetch-stage PC.
- `pred_taken` out 1: fetch prediction is taken.
- `pred_target` out 32: predicted target; `{entry.target, 2'b00}`.
- `stall` in 1: pipeline freeze; suppresses table updates.
- `res_valid` in 1: memory-stage instruction is valid and is being resolved this cycle.
- `res_pc` in 32: PC of the resolving instruction.
- `res_is_br` in 1: resolving instruction is BEQ or BNE.
- `res_taken` in 1: actual branch outcome.
- `res_target` in 32: actual branch target.
- `res_pred_taken` in 1: `pred_taken` carried down the pipeline with the instruction.
- `res_pred_target` in 32: `pred_target` carried down the pipeline.
- `btb_correct` out 1: prediction was right; no recovery needed.
- `btb_wrongtype` out 1: a non-branch instruction was predicted taken.

## Operation
- **Entry fields:** `valid`, `tag` (30−IDXW bits), `target` (30 bits), `ctr` (2 bits).
- **Addressing:** index = `pc[IDXW+1:2]`; tag = `pc[31:IDXW+2]`.
- **Lookup (combinational from table registers):**
  - hit = `valid && tag match`.
  - `pred_taken = hit && ctr[1]`.
  - `pred_target` = entry target when hit, else 0.
- **Resolution (combinational):**
  - `btb_wrongtype = res_valid && res_pred_taken && !res_is_br`.
  - `btb_correct = !res_valid || (res_pred_taken == (res_is_br && res_taken) && (!res_pred_taken || res_pred_target == res_target))`.
- **Update on a rising edge when `res_valid && !stall`:**
  - Branch, hit on `res_pc`: `ctr` saturating +1 if taken, −1 if not taken; on taken, `target` ← `res_target[31:2]`.
  - Branch, miss, taken: allocate the entry with `valid=1`, new tag, target, `ctr=2'b10`, overwriting any previous occupant.
  - Branch, miss, not taken: no change.
  - Non-branch, hit: clear `valid` (removes an aliased entry).
  - Non-branch, miss: no change.
- **Counter encoding:** 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Saturates at 00 and 11; never wraps.

## Timing
- Prediction has zero latency: combinational in the same cycle as `pc_f`.
- `btb_correct` and `btb_wrongtype` have zero latency relative to the `res_*` inputs.
- Table writes become visible on the cycle after the update edge. Fetch lookup and resolve update to the same index in the same cycle: lookup returns the old contents.
- **Reset (async, `nRST` low):**
  - Every entry gets `valid=0`, `ctr=2'b01`; tag and target are cleared to 0.
  - Outputs while in reset: `pred_taken=0`, `pred_target=0`, `btb_correct=1` unless `res_valid`, `btb_wrongtype=0` unless driven by inputs.
- Reset asserted mid-update: the update is lost; the table reflects reset values immediately.
- `stall` high: resolution outputs are still driven; the table does not change.

## Configuration
- `BTB_STATS_EN` defined:
  - Adds output `lookups` (32-bit): counts cycles with `res_valid && !stall`.
  - Adds output `mispredicts` (32-bit): counts cycles with `res_valid && !stall && !btb_correct`.
  - Both reset to 0 and wrap at 2^32.
- `BTB_STATS_EN` not defined: the ports and counters do not exist; behaviour is otherwise identical.

## Structure
- Add to `cpu_types_pkg`:
  - `btb_entry_t` packed struct: valid, tag, target, ctr.
  - `btbctr_t` (2-bit) and constants `BTB_WEAK_T = 2'b10`, `BTB_WEAK_NT = 2'b01`.
  - Default `BTB_ENTRIES = 16`.
- Sub-module `btb_counter2`: combinational saturating up/down for one 2-bit counter, instantiated once on the update path.

## Test plan
- **Reset:** assert `nRST` low, release, present `pc_f=0x40` → `pred_taken=0`, `pred_target=0`.
- **Allocate and predict:** resolve branch at `0x40`, taken, target `0x100`, pred 0 → `btb_correct=0`. Next cycle with `pc_f=0x40` → `pred_taken=1`, `pred_target=0x100`.
- **Counter hysteresis:** from `ctr=10`, resolve one not-taken → `ctr=01`, `pred_taken=0`. Four takens → `ctr=11` (saturated). One not-taken → still predicts taken.
- **Wrongtype:** allocate `0x80`, then resolve a non-branch at `0x80` with `res_pred_taken=1` → `btb_wrongtype=1`, `btb_correct=0`. Next cycle `pred_taken=0` at `0x80`.
- **Alias and target mismatch:** with ENTRIES=16, allocate `0x40`, then resolve a taken branch at `0x80` (same index) → entry retagged. `pc_f=0x40` → `pred_taken=0`. Separately, `res_pred_target=0x100` with `res_target=0x104` → `btb_correct=0`.
- **Stall and collision:** `stall=1` during a taken resolve → table unchanged. Same-cycle lookup and update at one index → old value on lookup, new value the next cycle.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared MIPS core types: branch target buffer entry layout, counter encoding and default depth.
// Latency: n/a (types only). Backpressure: n/a.
// Tags are stored at the widest size any legal depth needs (28 bits, 4 entries) and zero-extended.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [1:0]  btbctr_t;

    localparam int      BTB_ENTRIES = 16;
    localparam int      BTB_TAGW    = 28;
    localparam btbctr_t BTB_WEAK_T  = 2'b10;
    localparam btbctr_t BTB_WEAK_NT = 2'b01;

    typedef logic [BTB_TAGW-1:0] btb_tag_t;

    typedef struct packed {
        logic        valid;
        btb_tag_t    tag;
        logic [29:0] target;
        btbctr_t     ctr;
    } btb_entry_t;

endpackage

// File: rtl/btb_counter2.sv
// Saturating 2-bit up/down direction counter step (00 strong-NT .. 11 strong-T).
// Latency: combinational. Backpressure: none.
// Saturates at both ends; never wraps.
module btb_counter2
    import cpu_types_pkg::*;
(
    input  btbctr_t ctr,
    input  logic    up,
    output btbctr_t ctr_nxt
);

    always_comb begin
        ctr_nxt = ctr;
        if (up && ctr != 2'b11)
            ctr_nxt = ctr + 2'd1;
        else if (!up && ctr != 2'b00)
            ctr_nxt = ctr - 2'd1;
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: fetch-stage next-PC prediction, memory-stage resolution and table update.
// Latency: prediction and resolution combinational; table writes visible the cycle after the edge.
// Backpressure: stall freezes the table (outputs still driven). Optional BTB_STATS_EN adds counters.
module branch_target_buffer
    import cpu_types_pkg::*;
#(
    parameter int ENTRIES = BTB_ENTRIES
) (
    input  logic        CLK,
    input  logic        nRST,
    input  word_t       pc_f,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        stall,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic        res_is_br,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    input  logic        res_pred_taken,
    input  logic [31:0] res_pred_target,
    output logic        btb_correct,
    output logic        btb_wrongtype
`ifdef BTB_STATS_EN
    ,
    output logic [31:0] lookups,
    output logic [31:0] mispredicts
`endif
);

    localparam int IDXW = $clog2(ENTRIES);

    btb_entry_t      table_q [ENTRIES];
    logic [IDXW-1:0] f_idx, r_idx;
    btb_tag_t        f_tag, r_tag;
    btb_entry_t      f_ent, r_ent, upd_ent;
    logic            f_hit, r_hit, upd_we;
    btbctr_t         ctr_nxt;
    logic            unused_low_bits;

    assign unused_low_bits = ^{pc_f[1:0], res_pc[1:0], res_target[1:0]};

    assign f_idx = pc_f[IDXW+1:2];
    assign f_tag = btb_tag_t'(pc_f[31:IDXW+2]);
    assign r_idx = res_pc[IDXW+1:2];
    assign r_tag = btb_tag_t'(res_pc[31:IDXW+2]);

    assign f_ent = table_q[f_idx];
    assign r_ent = table_q[r_idx];
    assign f_hit = f_ent.valid && (f_ent.tag == f_tag);
    assign r_hit = r_ent.valid && (r_ent.tag == r_tag);

    assign pred_taken  = f_hit && f_ent.ctr[1];
    assign pred_target = f_hit ? {f_ent.target, 2'b00} : 32'd0;

    assign btb_wrongtype = res_valid && res_pred_taken && !res_is_br;
    assign btb_correct   = !res_valid ||
                           ((res_pred_taken == (res_is_br && res_taken)) &&
                            (!res_pred_taken || res_pred_target == res_target));

    btb_counter2 u_ctr (
        .ctr     (r_ent.ctr),
        .up      (res_taken),
        .ctr_nxt (ctr_nxt)
    );

    always_comb begin
        upd_ent = r_ent;
        upd_we  = 1'b0;
        if (res_is_br) begin
            if (r_hit) begin
                upd_ent.ctr = ctr_nxt;
                if (res_taken)
                    upd_ent.target = res_target[31:2];
                upd_we = 1'b1;
            end else if (res_taken) begin
                // Taken miss evicts whatever aliased occupant held this index.
                upd_ent.valid  = 1'b1;
                upd_ent.tag    = r_tag;
                upd_ent.target = res_target[31:2];
                upd_ent.ctr    = BTB_WEAK_T;
                upd_we         = 1'b1;
            end
        end else if (r_hit) begin
            upd_ent.valid = 1'b0;
            upd_we        = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: BTB_WEAK_NT};
            end
        end else if (res_valid && !stall && upd_we) begin
            table_q[r_idx] <= upd_ent;
        end
    end

`ifdef BTB_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lookups     <= '0;
            mispredicts <= '0;
        end else if (res_valid && !stall) begin
            lookups <= lookups + 32'd1;
            if (!btb_correct)
                mispredicts <= mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed vector bench for branch_target_buffer: one vector per cycle, outputs sampled on the falling edge.
// Each vector's update lands on the following rising edge, so lookups see the table before that vector.
module tb_branch_target_buffer;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    word_t       pc_f;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        stall, res_valid, res_is_br, res_taken, res_pred_taken;
    logic [31:0] res_pc, res_target, res_pred_target;
    logic        btb_correct, btb_wrongtype;
`ifdef BTB_STATS_EN
    logic [31:0] lookups, mispredicts;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    branch_target_buffer dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .pc_f            (pc_f),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .stall           (stall),
        .res_valid       (res_valid),
        .res_pc          (res_pc),
        .res_is_br       (res_is_br),
        .res_taken       (res_taken),
        .res_target      (res_target),
        .res_pred_taken  (res_pred_taken),
        .res_pred_target (res_pred_target),
        .btb_correct     (btb_correct),
        .btb_wrongtype   (btb_wrongtype)
`ifdef BTB_STATS_EN
        ,
        .lookups         (lookups),
        .mispredicts     (mispredicts)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic        stl, rv;
        logic [31:0] rpc;
        logic        br, tk;
        logic [31:0] tgt;
        logic        ppt;
        logic [31:0] pptgt;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_cor, e_wt;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    function automatic vec_t mk(logic [31:0] pc, logic stl, logic rv, logic [31:0] rpc,
                                logic br, logic tk, logic [31:0] tgt, logic ppt,
                                logic [31:0] pptgt, logic e_pt, logic [31:0] e_ptgt,
                                logic e_cor, logic e_wt);
        vec_t v;
        v.pc = pc; v.stl = stl; v.rv = rv; v.rpc = rpc; v.br = br; v.tk = tk;
        v.tgt = tgt; v.ppt = ppt; v.pptgt = pptgt; v.e_pt = e_pt; v.e_ptgt = e_ptgt;
        v.e_cor = e_cor; v.e_wt = e_wt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        pc_f = v.pc; stall = v.stl; res_valid = v.rv; res_pc = v.rpc;
        res_is_br = v.br; res_taken = v.tk; res_target = v.tgt;
        res_pred_taken = v.ppt; res_pred_target = v.pptgt;
    endtask

    initial begin
        //            pc_f     stl rv  res_pc   br tk  target   ppt pptgt     e_pt e_ptgt   cor wt
        vecs[0]  = mk(32'h40,  0, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0);
        vecs[1]  = mk(32'h40,  0, 1, 32'h40, 1, 1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 0);
        vecs[2]  = mk(32'h40,  0, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   1, 32'h100, 1, 0);
        vecs[3]  = mk(32'h40,  0, 1, 32'h40, 1, 0, 32'h0,   1, 32'h100, 1, 32'h100, 0, 0);
        vecs[4]  = mk(32'h40,  0, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, 32'h100, 1, 0);
        vecs[5]  = mk(32'h44,  0, 1, 32'h40, 1, 1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 0);
        vecs[6]  = mk(32'h44,  0, 1, 32'h40, 1, 1, 32'h100, 1, 32'h100, 0, 32'h0,   1, 0);
        vecs[7]  = mk(32'h44,  0, 1, 32'h40, 1, 1, 32'h100, 1, 32'h100, 0, 32'h0,   1, 0);
        vecs[8]  = mk(32'h44,  0, 1, 32'h40, 1, 1, 32'h100, 1, 32'h100, 0, 32'h0,   1, 0);
        vecs[9]  = mk(32'h40,  0, 1, 32'h40, 1, 0, 32'h0,   1, 32'h100, 1, 32'h100, 0, 0);
        vecs[10] = mk(32'h40,  0, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   1, 32'h100, 1, 0);
        vecs[11] = mk(32'h40,  0, 1, 32'h80, 1, 1, 32'h200, 0, 32'h0,   1, 32'h100, 0, 0);
        vecs[12] = mk(32'h40,  0, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0);
        vecs[13] = mk(32'h80,  0, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   1, 32'h200, 1, 0);
        vecs[14] = mk(32'h80,  0, 1, 32'h80, 0, 0, 32'h0,   1, 32'h200, 1, 32'h200, 0, 1);
        vecs[15] = mk(32'h80,  0, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0);
        vecs[16] = mk(32'h48,  0, 1, 32'h48, 1, 1, 32'h104, 1, 32'h100, 0, 32'h0,   0, 0);
        vecs[17] = mk(32'h48,  0, 1, 32'h48, 1, 1, 32'h104, 1, 32'h104, 1, 32'h104, 1, 0);
        vecs[18] = mk(32'h4C,  1, 1, 32'h4C, 1, 1, 32'h300, 0, 32'h0,   0, 32'h0,   0, 0);
        vecs[19] = mk(32'h4C,  0, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0);
        vecs[20] = mk(32'h4C,  0, 1, 32'h50, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0);
        vecs[21] = mk(32'h4C,  0, 0, 32'h50, 0, 0, 32'h0,   1, 32'h50,  0, 32'h0,   1, 0);
        vecs[22] = mk(32'h48,  0, 1, 32'h48, 1, 1, 32'h400, 1, 32'h104, 1, 32'h104, 0, 0);
        vecs[23] = mk(32'h48,  0, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   1, 32'h400, 1, 0);
        vecs[24] = mk(32'h4C,  0, 1, 32'h54, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0);
        vecs[25] = mk(32'h54,  0, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0);

        drive(vecs[0]);
        nRST = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_pred_taken", 32'(pred_taken), 32'd0);
        chk("reset_correct", 32'(btb_correct), 32'd1);
        nRST = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge CLK);
            #1;
            drive(vecs[i]);
            @(negedge CLK);
            chk($sformatf("v%0d_pred_taken", i), 32'(pred_taken), 32'(vecs[i].e_pt));
            chk($sformatf("v%0d_pred_target", i), pred_target, vecs[i].e_ptgt);
            chk($sformatf("v%0d_correct", i), 32'(btb_correct), 32'(vecs[i].e_cor));
            chk($sformatf("v%0d_wrongtype", i), 32'(btb_wrongtype), 32'(vecs[i].e_wt));
        end

`ifdef BTB_STATS_EN
        @(posedge CLK);
        #1;
        drive(vecs[0]);
        @(negedge CLK);
        chk("stats_lookups", lookups, 32'd14);
        chk("stats_mispredicts", mispredicts, 32'd8);
`endif

        // Reset arriving while a taken resolve is pending: table clears immediately, update lost.
        @(posedge CLK);
        #1;
        drive(mk(32'h48, 0, 1, 32'h58, 1, 1, 32'h500, 0, 32'h0, 0, 32'h0, 0, 0));
        #2;
        nRST = 1'b0;
        @(negedge CLK);
        chk("midrst_pred_taken", 32'(pred_taken), 32'd0);
        chk("midrst_pred_target", pred_target, 32'd0);
        chk("midrst_correct", 32'(btb_correct), 32'd0);
`ifdef BTB_STATS_EN
        chk("midrst_lookups", lookups, 32'd0);
`endif
        @(posedge CLK);
        #1;
        drive(vecs[0]);
        pc_f = 32'h58;
        @(negedge CLK);
        nRST = 1'b1;
        chk("rst_idle_correct", 32'(btb_correct), 32'd1);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("postrst_lost_update", 32'(pred_taken), 32'd0);
        pc_f = 32'h48;
        #1;
        chk("postrst_cleared", 32'(pred_taken), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
